// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential issue front-end for an external two-operand ALU.
// It holds a small register file and accepts 8-bit instructions over a
// valid/ready handshake. It drives registered operands and control into the
// ALU and writes the ALU result back into the register file and flags.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   instr_valid/ready  instruction handshake; instr = {op, rd, rs1, rs2}
//   ld_valid/addr/data register-file load port, usable in any state
//   aluin1/2, alu_ctrl registered ALU operands and op (alu_control)
//   aluout, alu_carry  ALU result inputs, sampled during write-back
//   result_valid/data  one-cycle write-back report
//   carry_flag         last captured alu_carry
//   zero_flag          last captured aluout == 0
module alu_issue_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [7:0]    instr,
  input  logic          ld_valid,
  input  logic [1:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] aluin1,
  output logic [DW-1:0] aluin2,
  output logic [1:0]    alu_control,
  input  logic [DW-1:0] aluout,
  input  logic          alu_carry,
  output logic          result_valid,
  output logic [DW-1:0] result_data,
  output logic          carry_flag,
  output logic          zero_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [1:0]    op_q, rd_q, rs1_q, rs2_q;
  logic [DW-1:0] rf [NREG];
  logic          accept;

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = EXEC;
      end
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      aluin1       <= '0;
      aluin2       <= '0;
      alu_control  <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      carry_flag   <= 1'b0;
      zero_flag    <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      result_valid <= 1'b0;

      if (accept) begin
        op_q  <= instr[7:6];
        rd_q  <= instr[5:4];
        rs1_q <= instr[3:2];
        rs2_q <= instr[1:0];
      end

      // Operands are read from the current register-file contents, so a load
      // landing at the end of EXEC is not seen by this instruction.
      if (state == EXEC) begin
        aluin1      <= rf[rs1_q];
        aluin2      <= rf[rs2_q];
        alu_control <= op_q;
      end

      if (ld_valid) rf[ld_addr] <= ld_data;

      // Placed after the load so write-back overrides a same-cycle load to rd.
      if (state == WB) begin
        rf[rd_q]     <= aluout;
        result_data  <= aluout;
        carry_flag   <= alu_carry;
        zero_flag    <= (aluout == '0);
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. The external ALU is modelled here:
// 00 add (carry out), 01 subtract (carry = borrow), 10 and, 11 or.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr;
  logic        ld_valid;
  logic [1:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] aluin1, aluin2;
  logic [1:0]  alu_control;
  logic [15:0] aluout;
  logic        alu_carry;
  logic        result_valid;
  logic [15:0] result_data;
  logic        carry_flag, zero_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(16), .NREG(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .aluin1       (aluin1),
    .aluin2       (aluin2),
    .alu_control  (alu_control),
    .aluout       (aluout),
    .alu_carry    (alu_carry),
    .result_valid (result_valid),
    .result_data  (result_data),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag)
  );

  always_comb begin
    logic [16:0] t;
    t = '0;
    case (alu_control)
      2'b00:   t = {1'b0, aluin1} + {1'b0, aluin2};
      2'b01:   t = {1'b0, aluin1} - {1'b0, aluin2};
      2'b10:   t = {1'b0, aluin1 & aluin2};
      default: t = {1'b0, aluin1 | aluin2};
    endcase
    aluout    = t[15:0];
    alu_carry = t[16];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_valid = 1'b0;
  endtask

  // Accept in cycle N; returns in cycle N+1 (EXEC).
  task automatic issue(input logic [1:0] op, rd, rs1, rs2);
    instr_valid = 1'b1;
    instr = {op, rd, rs1, rs2};
    step();
    instr_valid = 1'b0;
  endtask

  // Full instruction with checks at N+2 (operands) and N+3 (result).
  task automatic run_op(input string name, input logic [1:0] op, rd, rs1, rs2,
                        input logic [15:0] e1, e2, eres, input logic ecar);
    issue(op, rd, rs1, rs2);
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL %s ready_exec got %b exp 0", name, instr_ready);
    end
    step();
    checks++;
    if ({aluin1, aluin2, alu_control} !== {e1, e2, op}) begin
      errors++;
      $display("FAIL %s operands got %h %h %b exp %h %h %b", name, aluin1, aluin2, alu_control, e1, e2, op);
    end
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL %s early_valid got %b exp 0", name, result_valid);
    end
    step();
    checks++;
    if ({result_valid, result_data, carry_flag, zero_flag} !== {1'b1, eres, ecar, (eres == 16'h0)}) begin
      errors++;
      $display("FAIL %s result got v=%b d=%h c=%b z=%b exp v=1 d=%h c=%b z=%b", name,
               result_valid, result_data, carry_flag, zero_flag, eres, ecar, (eres == 16'h0));
    end
    step();
    checks++;
    if (result_valid !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_wb got v=%b r=%b exp v=0 r=1", name, result_valid, instr_ready);
    end
  endtask

  task automatic test_reset();
    load(2'd1, 16'h1234);
    issue(2'b00, 2'd2, 2'd1, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({aluin1, aluin2, alu_control, result_data, carry_flag, zero_flag, result_valid, instr_ready}
        !== {16'h0, 16'h0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %b %h %b %b %b %b", aluin1, aluin2, alu_control,
               result_data, carry_flag, zero_flag, result_valid, instr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (result_valid !== 1'b0 || instr_ready !== 1'b1) begin
        errors++; $display("FAIL reset_no_wb cyc %0d got v=%b r=%b exp v=0 r=1", i, result_valid, instr_ready);
      end
    end
    // Register file must be cleared: r1 reads back as zero.
    run_op("reset_rf", 2'b00, 2'd3, 2'd1, 2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_add_carry();
    load(2'd0, 16'hffff);
    load(2'd1, 16'h0001);
    run_op("add_carry", 2'b00, 2'd2, 2'd0, 2'd1, 16'hffff, 16'h0001, 16'h0000, 1'b1);
    run_op("add_carry_r2", 2'b11, 2'd3, 2'd2, 2'd1, 16'h0000, 16'h0001, 16'h0001, 1'b0);
  endtask

  task automatic test_add_nocarry();
    load(2'd0, 16'h0000);
    load(2'd1, 16'h0001);
    run_op("add_nocarry", 2'b00, 2'd2, 2'd0, 2'd1, 16'h0000, 16'h0001, 16'h0001, 1'b0);
  endtask

  task automatic test_back_to_back();
    load(2'd0, 16'h0003);
    load(2'd1, 16'h0005);
    instr_valid = 1'b1;
    instr = {2'b00, 2'd2, 2'd0, 2'd1};
    step();                                        // N+1 EXEC of A
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_exec got %b exp 0", instr_ready);
    end
    instr = {2'b10, 2'd3, 2'd0, 2'd1};
    step();                                        // N+2 WB of A
    checks++;
    if (instr_ready !== 1'b0 || {aluin1, aluin2, alu_control} !== {16'h0003, 16'h0005, 2'b00}) begin
      errors++;
      $display("FAIL b2b_wb_a got r=%b %h %h %b exp r=0 0003 0005 00", instr_ready, aluin1, aluin2, alu_control);
    end
    step();                                        // N+3 IDLE, B accepted here
    checks++;
    if (instr_ready !== 1'b1 || result_valid !== 1'b1 || result_data !== 16'h0008) begin
      errors++;
      $display("FAIL b2b_accept_b got r=%b v=%b d=%h exp r=1 v=1 d=0008", instr_ready, result_valid, result_data);
    end
    step();                                        // EXEC of B
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_exec_b got r=%b v=%b exp r=0 v=0", instr_ready, result_valid);
    end
    step();                                        // WB of B
    checks++;
    if ({aluin1, aluin2, alu_control} !== {16'h0003, 16'h0005, 2'b10}) begin
      errors++; $display("FAIL b2b_ops_b got %h %h %b exp 0003 0005 10", aluin1, aluin2, alu_control);
    end
    step();
    checks++;
    if (result_valid !== 1'b1 || result_data !== 16'h0001) begin
      errors++; $display("FAIL b2b_result_b got v=%b d=%h exp v=1 d=0001", result_valid, result_data);
    end
    step();
  endtask

  task automatic test_hazard();
    load(2'd0, 16'h0a00);
    load(2'd1, 16'h0a01);
    run_op("chain1", 2'b00, 2'd0, 2'd0, 2'd1, 16'h0a00, 16'h0a01, 16'h1401, 1'b0);
    run_op("chain2", 2'b00, 2'd0, 2'd0, 2'd1, 16'h1401, 16'h0a01, 16'h1e02, 1'b0);
  endtask

  task automatic test_collision();
    // r0=1e02, r1=0a01; load r2 during EXEC (not seen), load r2 during WB (dropped).
    load(2'd2, 16'h1111);
    issue(2'b10, 2'd2, 2'd2, 2'd1);                 // EXEC cycle now
    ld_valid = 1'b1; ld_addr = 2'd2; ld_data = 16'h2222;
    step();                                        // WB cycle
    checks++;
    if (aluin1 !== 16'h1111) begin
      errors++; $display("FAIL exec_preload got %h exp 1111", aluin1);
    end
    ld_data = 16'hdead;
    step();
    ld_valid = 1'b0;
    checks++;
    if (result_data !== 16'h0001) begin
      errors++; $display("FAIL collide_result got %h exp 0001", result_data);
    end
    step();
    run_op("collide_rf", 2'b11, 2'd3, 2'd2, 2'd2, 16'h0001, 16'h0001, 16'h0001, 1'b0);
  endtask

  task automatic test_ctrl_ops();
    load(2'd0, 16'hf0f0);
    load(2'd1, 16'habcd);
    run_op("op_sub", 2'b01, 2'd2, 2'd0, 2'd1, 16'hf0f0, 16'habcd, 16'h4523, 1'b0);
    run_op("op_and", 2'b10, 2'd3, 2'd0, 2'd1, 16'hf0f0, 16'habcd, 16'ha0c0, 1'b0);
    run_op("op_or",  2'b11, 2'd2, 2'd0, 2'd1, 16'hf0f0, 16'habcd, 16'hfbfd, 1'b0);
    run_op("op_sub_borrow", 2'b01, 2'd3, 2'd1, 2'd0, 16'habcd, 16'hf0f0, 16'hbadd, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    #12 rst_n = 1'b1;
    step();
    checks++;
    if ({instr_ready, result_valid, aluin1, aluin2, alu_control} !== {1'b1, 1'b0, 16'h0, 16'h0, 2'b00}) begin
      errors++; $display("FAIL por_state got r=%b v=%b %h %h %b", instr_ready, result_valid, aluin1, aluin2, alu_control);
    end
    test_reset();
    test_add_carry();
    test_add_nocarry();
    test_back_to_back();
    test_hazard();
    test_collision();
    test_ctrl_ops();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
